// File: rtl/nibble_serial_sub.sv
// Serial A-B subtractor: one 4-bit add slice per clock (A + ~B + 1, carry chained),
// producing difference plus borrow/zero/signed-overflow under a start/busy/done handshake.
module nibble_serial_sub #(
  parameter  int WIDTH = 8,
  localparam int NIB   = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             ovf
);

  localparam int KW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);
  localparam int MSB = WIDTH - 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [KW-1:0]    k;
  logic             c;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] work;
  logic [4:0]       slice;
  logic [WIDTH-1:0] work_nx;

  // Same 4-bit slice as the datapath adder; subtraction comes from the caller inverting y.
  function automatic logic [4:0] add_slice(input logic [3:0] x, input logic [3:0] y,
                                           input logic cin);
    return {1'b0, x} + {1'b0, y} + {4'b0000, cin};
  endfunction

  always_comb begin
    slice            = add_slice(a_r[4*k +: 4], ~b_r[4*k +: 4], c);
    work_nx          = work;
    work_nx[4*k +: 4] = slice[3:0];
  end

  // Operand and working-difference registers carry no reset; control below does.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      a_r <= a;
      b_r <= b;
    end else if (state == RUN) begin
      work <= work_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      k      <= '0;
      c      <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy  <= 1'b1;
            c     <= 1'b1;
            k     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          c <= slice[4];
          k <= k + 1'b1;
          if (k == K_LAST) begin
            // Final edge: publish the full difference including this nibble.
            diff   <= work_nx;
            borrow <= ~slice[4];
            zero   <= (work_nx == '0);
            ovf    <= (a_r[MSB] != b_r[MSB]) && (work_nx[MSB] != a_r[MSB]);
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Bench for nibble_serial_sub at WIDTH=4/8/16 against an arithmetic reference model.
module tb_nibble_serial_sub;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        borrow;
    logic        zero;
    logic        ovf;
    logic [15:0] diff;
  } obs_t;

  logic clk;
  logic rst4, rst8, rst16;
  logic start4, start8, start16;
  logic [3:0]  a4, b4, diff4;
  logic [7:0]  a8, b8, diff8;
  logic [15:0] a16, b16, diff16;
  logic busy4, done4, borrow4, zero4, ovf4;
  logic busy8, done8, borrow8, zero8, ovf8;
  logic busy16, done16, borrow16, zero16, ovf16;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state per DUT index (0:W4, 1:W8, 2:W16)
  bit          pend [3];
  int          rem  [3];
  bit          edone[3];
  logic [15:0] hdiff[3];
  bit          hb [3], hz [3], ho [3];
  logic [15:0] qd [3];
  bit          qb [3], qz [3], qo [3];
  int          nops [3];

  nibble_serial_sub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4), .zero(zero4), .ovf(ovf4));
  nibble_serial_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .zero(zero8), .ovf(ovf8));
  nibble_serial_sub #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst16), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .diff(diff16), .borrow(borrow16), .zero(zero16), .ovf(ovf16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int w_of(int i);
    return 4 << i;
  endfunction

  function automatic obs_t get_obs(int i);
    obs_t o;
    o = '0;
    case (i)
      0: begin o.busy = busy4;  o.done = done4;  o.borrow = borrow4;  o.zero = zero4;
               o.ovf = ovf4;  o.diff = {12'h000, diff4}; end
      1: begin o.busy = busy8;  o.done = done8;  o.borrow = borrow8;  o.zero = zero8;
               o.ovf = ovf8;  o.diff = {8'h00, diff8}; end
      default: begin o.busy = busy16; o.done = done16; o.borrow = borrow16; o.zero = zero16;
               o.ovf = ovf16; o.diff = diff16; end
    endcase
    return o;
  endfunction

  function automatic logic get_rst(int i);
    case (i)
      0: return rst4;
      1: return rst8;
      default: return rst16;
    endcase
  endfunction

  function automatic logic get_start(int i);
    case (i)
      0: return start4;
      1: return start8;
      default: return start16;
    endcase
  endfunction

  function automatic logic [15:0] get_a(int i);
    case (i)
      0: return {12'h000, a4};
      1: return {8'h00, a8};
      default: return a16;
    endcase
  endfunction

  function automatic logic [15:0] get_b(int i);
    case (i)
      0: return {12'h000, b4};
      1: return {8'h00, b8};
      default: return b16;
    endcase
  endfunction

  function automatic obs_t model_obs(int i);
    obs_t o;
    o.busy = pend[i]; o.done = edone[i]; o.borrow = hb[i]; o.zero = hz[i];
    o.ovf = ho[i]; o.diff = hdiff[i];
    return o;
  endfunction

  task automatic clear_model(int i);
    pend[i] = 0; rem[i] = 0; edone[i] = 0; hdiff[i] = '0; hb[i] = 0; hz[i] = 0; ho[i] = 0;
  endtask

  // Plain integer arithmetic: unsigned difference, unsigned compare, signed range test.
  task automatic model_calc(int i, logic [15:0] av, logic [15:0] bv);
    int w, mask, half, ua, ub, sa, sb, sd;
    w = w_of(i);
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    ua = int'(av) & mask;
    ub = int'(bv) & mask;
    sa = (ua >= half) ? ua - 2 * half : ua;
    sb = (ub >= half) ? ub - 2 * half : ub;
    sd = sa - sb;
    qd[i] = 16'((ua - ub) & mask);
    qb[i] = (ua < ub);
    qz[i] = (((ua - ub) & mask) == 0);
    qo[i] = (sd < -half) || (sd >= half);
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (get_rst(i)) begin
        clear_model(i);
      end else begin
        edone[i] = 0;
        if (pend[i]) begin
          rem[i] = rem[i] - 1;
          if (rem[i] == 0) begin
            pend[i] = 0; edone[i] = 1;
            hdiff[i] = qd[i]; hb[i] = qb[i]; hz[i] = qz[i]; ho[i] = qo[i];
          end
        end else if (get_start(i)) begin
          model_calc(i, get_a(i), get_b(i));
          pend[i] = 1;
          rem[i] = w_of(i) / 4;
          nops[i] = nops[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      obs_t got, exp;
      if (get_rst(i)) clear_model(i);
      got = get_obs(i);
      exp = model_obs(i);
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL cycle_check w%0d t=%0t got busy=%b done=%b diff=%h brw=%b z=%b ovf=%b required busy=%b done=%b diff=%h brw=%b z=%b ovf=%b",
                 w_of(i), $time, got.busy, got.done, got.diff, got.borrow, got.zero, got.ovf,
                 exp.busy, exp.done, exp.diff, exp.borrow, exp.zero, exp.ovf);
      end
    end
  end

  task automatic check_obs(string name, obs_t got, obs_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got busy=%b done=%b diff=%h brw=%b z=%b ovf=%b required busy=%b done=%b diff=%h brw=%b z=%b ovf=%b",
               name, got.busy, got.done, got.diff, got.borrow, got.zero, got.ovf,
               exp.busy, exp.done, exp.diff, exp.borrow, exp.zero, exp.ovf);
    end
  endtask

  // Literal result expected in the done cycle; pins both the DUT and the model.
  task automatic check_result(string name, int i, logic [15:0] d, bit br, bit z, bit o);
    obs_t exp;
    exp.busy = 0; exp.done = 1; exp.borrow = br; exp.zero = z; exp.ovf = o; exp.diff = d;
    check_obs({name, "_dut"}, get_obs(i), exp);
    check_obs({name, "_model"}, model_obs(i), exp);
  endtask

  task automatic set_in(int i, logic st, logic [15:0] av, logic [15:0] bv);
    case (i)
      0: begin start4 = st;  a4 = av[3:0]; b4 = bv[3:0]; end
      1: begin start8 = st;  a8 = av[7:0]; b8 = bv[7:0]; end
      default: begin start16 = st; a16 = av; b16 = bv; end
    endcase
  endtask

  task automatic issue(int i, logic [15:0] av, logic [15:0] bv);
    set_in(i, 1'b1, av, bv);
    @(negedge clk);
    set_in(i, 1'b0, 16'($urandom), 16'($urandom));
  endtask

  task automatic wait_done(int i, string name);
    int n;
    n = 0;
    while (get_obs(i).done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (get_obs(i).done !== 1'b1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout got no done within 20 cycles required done", name);
    end
  endtask

  function automatic logic [15:0] rnd(int i);
    int w, mask;
    w = w_of(i);
    mask = (1 << w) - 1;
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'(mask);
      2: return 16'(1 << (w - 1));
      3: return 16'((1 << (w - 1)) - 1);
      default: return 16'($urandom & mask);
    endcase
  endfunction

  initial begin
    obs_t zobs;
    int cyc;
    zobs = '0;
    for (int i = 0; i < 3; i++) begin
      clear_model(i);
      nops[i] = 0;
    end
    rst4 = 1; rst8 = 1; rst16 = 1;
    for (int i = 0; i < 3; i++) set_in(i, 1'b0, 16'h0000, 16'h0000);
    repeat (2) @(posedge clk);
    #2;
    rst4 = 0; rst8 = 0; rst16 = 0;
    @(negedge clk);

    // Directed WIDTH=8 cases, each new start issued in the previous done cycle
    issue(1, 16'h35, 16'h12); wait_done(1, "sub_35_12"); check_result("sub_35_12", 1, 16'h23, 0, 0, 0);
    issue(1, 16'h12, 16'h35); wait_done(1, "sub_12_35"); check_result("sub_12_35", 1, 16'hDD, 1, 0, 0);
    issue(1, 16'h5A, 16'h5A); wait_done(1, "sub_5a_5a"); check_result("sub_5a_5a", 1, 16'h00, 0, 1, 0);
    issue(1, 16'h80, 16'h01); wait_done(1, "sub_80_01"); check_result("sub_80_01", 1, 16'h7F, 0, 0, 1);
    issue(1, 16'h7F, 16'hFF); wait_done(1, "sub_7f_ff"); check_result("sub_7f_ff", 1, 16'h80, 1, 0, 1);

    // Start while busy must be ignored
    issue(1, 16'h35, 16'h12);
    set_in(1, 1'b1, 16'h00, 16'hFF);
    @(negedge clk);
    set_in(1, 1'b0, 16'h00, 16'h00);
    wait_done(1, "busy_ignore"); check_result("busy_ignore", 1, 16'h23, 0, 0, 0);
    issue(1, 16'h10, 16'h01); wait_done(1, "sub_10_01"); check_result("sub_10_01", 1, 16'h0F, 0, 0, 0);

    // Reset one cycle into a WIDTH=16 operation
    issue(2, 16'h1234, 16'h0234);
    @(posedge clk);
    #2 rst16 = 1;
    #1 check_obs("async_reset_w16", get_obs(2), zobs);
    @(negedge clk);
    @(posedge clk);
    #2 rst16 = 0;
    repeat (6) @(negedge clk);
    issue(2, 16'h1234, 16'h0234); wait_done(2, "after_reset"); check_result("after_reset", 2, 16'h1000, 0, 0, 0);

    // Randomized phase on all three widths
    for (int i = 0; i < 3; i++) nops[i] = 0;
    cyc = 0;
    while ((nops[0] < 1000 || nops[1] < 1000 || nops[2] < 1000) && cyc < 60000) begin
      for (int i = 0; i < 3; i++) set_in(i, 1'($urandom_range(0, 1)), rnd(i), rnd(i));
      @(negedge clk);
      cyc++;
    end
    for (int i = 0; i < 3; i++) set_in(i, 1'b0, 16'h0000, 16'h0000);
    if (nops[0] < 1000 || nops[1] < 1000 || nops[2] < 1000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL random_budget got ops %0d/%0d/%0d required 1000 each", nops[0], nops[1], nops[2]);
    end
    repeat (10) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
